// File: rtl/bin_to_bcd_seq_if.sv
// Bus between the binary source and the BCD converter feeding the display path.
// start is a request sampled only while the converter is idle (busy=0); done is a one-cycle strobe marking new digits.
interface bin_to_bcd_seq_if #(
  parameter int IN_WIDTH = 10
);
  logic                start;
  logic [IN_WIDTH-1:0] bin;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [3:0]          bcd0;
  logic [3:0]          bcd1;
  logic [3:0]          bcd2;

  modport master (
    output start, bin,
    input  busy, done, ovf, bcd0, bcd1, bcd2
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, bcd0, bcd1, bcd2
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, with saturating 3-digit output.
// Optional leading-zero blanking of bcd2/bcd1 (value 4'hF) is enabled by defining BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus,
  output logic [0:0]       dbg_state_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int         CW    = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(IN_WIDTH);

  logic [0:0]          state_q, state_d;
  logic [IN_WIDTH-1:0] sh_q, sh_d;
  logic [15:0]         dig_q, dig_d, dig_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [3:0]          bcd0_q, bcd0_d;
  logic [3:0]          bcd1_q, bcd1_d;
  logic [3:0]          bcd2_q, bcd2_d;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bcd0_d  = bcd0_q;
    bcd1_d  = bcd1_q;
    bcd2_d  = bcd2_q;
    dig_adj = dig_q;

    for (int i = 0; i < 4; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin;
          dig_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {dig_d, sh_d} = {dig_adj, sh_q} << 1;
        cnt_d = cnt_q - 4'd1;
        // Final shift: load the display registers from the freshly shifted digits.
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (dig_d[15:12] != 4'd0) begin
            ovf_d  = 1'b1;
            bcd2_d = 4'd9;
            bcd1_d = 4'd9;
            bcd0_d = 4'd9;
          end else begin
            ovf_d  = 1'b0;
            bcd2_d = dig_d[11:8];
            bcd1_d = dig_d[7:4];
            bcd0_d = dig_d[3:0];
`ifdef BCD_BLANK_EN
            if (dig_d[11:8] == 4'd0) bcd2_d = 4'hF;
            if (dig_d[11:8] == 4'd0 && dig_d[7:4] == 4'd0) bcd1_d = 4'hF;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd0_q  <= 4'd0;
      bcd1_q  <= 4'd0;
      bcd2_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bcd0_q  <= bcd0_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
    end
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd0    = bcd0_q;
  assign bus.bcd1    = bcd1_q;
  assign bus.bcd2    = bcd2_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: reset/abort, nominal, saturation, ignored start, back-to-back, blanking.
module tb_bin_to_bcd_seq;

  logic       clk;
  logic       rst;
  logic [0:0] dbg_state;
  int         checks;
  int         errors;

  bin_to_bcd_seq_if #(.IN_WIDTH(10)) bus ();

  bin_to_bcd_seq #(.IN_WIDTH(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

`ifdef BCD_BLANK_EN
  localparam logic [11:0] EXP_0  = 12'hFF0;
  localparam logic [11:0] EXP_7  = 12'hFF7;
  localparam logic [11:0] EXP_12 = 12'hF12;
`else
  localparam logic [11:0] EXP_0  = 12'h000;
  localparam logic [11:0] EXP_7  = 12'h007;
  localparam logic [11:0] EXP_12 = 12'h012;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] digits();
    return {bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge following done.
  task automatic do_conv(input string tag, input logic [9:0] v,
                         input logic [11:0] exp_dig, input logic exp_ovf);
    int n;
    int busy_n;
    bus.start = 1'b1;
    bus.bin   = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    busy_n = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_n++;
      bus.bin = 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 10);
    check({tag, "_busy"}, busy_n, 10);
    check({tag, "_dig"}, {20'd0, digits()}, {20'd0, exp_dig});
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    @(posedge clk); #1;
    check({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int n;
    int m;
    int dn;
    int lat;
    logic [11:0] dig_at_done;
    logic        ovf_at_done;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    check("rst_dig",  {20'd0, digits()}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);

    do_conv("nom473", 10'd473, 12'h473, 1'b0);

    // Abort mid-conversion at edge k+4
    bus.start = 1'b1;
    bus.bin   = 10'd321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_ovf",  {31'd0, bus.ovf},  32'd0);
    check("abort_dig",  {20'd0, digits()}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("abort_no_done", dn, 0);
    do_conv("zero", 10'd0, EXP_0, 1'b0);

    do_conv("b999",  10'd999,  12'h999, 1'b0);
    do_conv("b1000", 10'd1000, 12'h999, 1'b1);
    do_conv("b1023", 10'd1023, 12'h999, 1'b1);

    // Start ignored while busy, bin scrambled every cycle
    bus.start = 1'b1;
    bus.bin   = 10'd256;
    @(posedge clk); #1;
    dn = 0;
    lat = 0;
    dig_at_done = '0;
    ovf_at_done = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      bus.start = (c == 3);
      bus.bin   = (c == 3) ? 10'd5 : 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
      if (bus.done) begin
        dn++;
        lat = c;
        dig_at_done = digits();
        ovf_at_done = bus.ovf;
      end
    end
    bus.start = 1'b0;
    check("ign_done_cnt", dn, 1);
    check("ign_lat", lat, 10);
    check("ign_dig", {20'd0, dig_at_done}, 32'h256);
    check("ign_ovf", {31'd0, ovf_at_done}, 32'd0);

    // Back-to-back: start held high, second accepted in the done cycle
    bus.start = 1'b1;
    bus.bin   = 10'd12;
    @(posedge clk); #1;
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_lat1", n, 10);
    check("b2b_dig1", {20'd0, digits()}, {20'd0, EXP_12});
    check("b2b_ovf1", {31'd0, bus.ovf}, 32'd0);
    bus.bin = 10'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m = 1;
    check("b2b_done_drop", {31'd0, bus.done}, 32'd0);
    check("b2b_accept", {31'd0, bus.busy}, 32'd1);
    while (!bus.done && m < 25) begin
      @(posedge clk); #1;
      m++;
    end
    check("b2b_gap", m, 11);
    check("b2b_dig2", {20'd0, digits()}, {20'd0, EXP_7});
    @(posedge clk); #1;

`ifdef BCD_BLANK_EN
    do_conv("blank5",   10'd5,   12'hFF5, 1'b0);
    do_conv("blank40",  10'd40,  12'hF40, 1'b0);
    do_conv("blank100", 10'd100, 12'h100, 1'b0);
`else
    do_conv("plain5",   10'd5,   12'h005, 1'b0);
    do_conv("plain40",  10'd40,  12'h040, 1'b0);
    do_conv("plain100", 10'd100, 12'h100, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that feeds the three-digit multiplexed 7-segment display path. It takes an unsigned binary value on a start strobe and runs a double-dabble conversion at one shift per clock. It then presents three registered BCD digits (units, tens, hundreds) to the digit mux/segment decoder, which is scanned by the anode-select controller. Digits are held stable between conversions, so the scanning stage never sees partial results.

## Interface
- IN_WIDTH, 10, width of binary input; legal range 4..13.
- clk  input  1  system clock (27 MHz board clock).
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  IN_WIDTH  unsigned value to convert; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- bcd0  output  4  units digit.
- bcd1  output  4  tens digit.
- bcd2  output  4  hundreds digit.
- ovf  output  1  last converted value exceeded 999; sticky until next done.

## Operation
- Reset:
  - Asserting rst forces IDLE immediately, asynchronously.
  - Output values: busy=0, done=0, ovf=0, bcd0=bcd1=bcd2=0.
  - Internal shift register and counter are cleared.
- FSM states:
  - IDLE:
    - start=1 captures bin into the shift register and clears four internal BCD digits (d0..d3).
    - Loads the iteration counter with IN_WIDTH and moves to SHIFT.
  - SHIFT, once per clock:
    - Each of d0..d3 that is >=5 gets 3 added (4-bit, no carry out).
    - The {d3,d2,d1,d0,shift_reg} vector is then shifted left by 1.
    - The counter decrements.
    - On the edge where the counter goes 1->0: output registers update, done is set for one cycle, and the FSM returns to IDLE.
- Four internal digits are used because IN_WIDTH<=13 gives a maximum value of 8191.
- Saturation: if d3!=0 at completion, outputs are 9,9,9 and ovf=1. Otherwise the outputs are d2,d1,d0 and ovf=0.
- start while busy is ignored; there is no queueing.
- bin changes after the accepting edge have no effect on the running conversion.
- bcd0..bcd2 and ovf change only on the done edge (or on reset).

## Timing
- start is accepted on edge k; busy=1 from after edge k through edge k+IN_WIDTH.
- After edge k+IN_WIDTH: busy=0, done=1, new digits are visible. Latency is IN_WIDTH clocks (10 by default).
- done drops after edge k+IN_WIDTH+1 unless a new conversion finishes there, which is impossible for IN_WIDTH>=4.
- The FSM is in IDLE during the done cycle, so a start that is high during the done cycle is accepted on that edge. Back-to-back throughput is therefore one conversion per IN_WIDTH+1 clocks.
- Reset mid-conversion: the conversion aborts, all outputs go to reset values, and no done is produced. The first start after rst deasserts is accepted normally.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Configuration
- Macro: BCD_BLANK_EN.
- Defined (leading-zero blanking):
  - bcd2 is forced to 4'hF when it is zero.
  - bcd1 is forced to 4'hF when both bcd2 and bcd1 are zero.
  - The segment decoder renders 4'hF as all segments off.
  - bcd0 is never blanked.
  - ovf=1 output (9,9,9) is unaffected.
  - Blanking is applied when the output registers load, so latency is unchanged.
- Undefined: digits are output as plain BCD, including leading zeros.

## Test plan
- Reset and idle:
  - Stimulus: rst=1 mid-conversion (edge k+4), then release, then start with bin=0.
  - Required response: no done from the aborted run; outputs are 0,0,0 with ovf=0 and busy=0 right after rst; the new run produces done after 10 clocks with digits 0,0,0 (or F,F,0 with BCD_BLANK_EN).
- Nominal conversion:
  - Stimulus: start pulse with bin=10'd473.
  - Required response: busy high for 10 cycles; done pulse on cycle 10; bcd2=4, bcd1=7, bcd0=3, ovf=0.
- Boundaries:
  - Stimulus: bin=999, then bin=1000, then bin=1023.
  - Required response: 9,9,9 with ovf=0; then 9,9,9 with ovf=1; then 9,9,9 with ovf=1.
- Ignored start and input stability:
  - Stimulus: start bin=256, pulse start with bin=5 at edge k+3, and change bin every cycle.
  - Required response: a single done with 2,5,6.
- Back-to-back:
  - Stimulus: hold start=1 with bin=12, then bin=7 in the done cycle.
  - Required response: the second done arrives exactly 11 clocks after the first, with 0,0,7 (or F,F,7 with BCD_BLANK_EN).
- Blanking:
  - Stimulus: with BCD_BLANK_EN, convert 5, then 40, then 100.
  - Required response: F,F,5, then F,4,0, then 1,0,0.
